// File: rtl/priv_1_12_trap_ctrl.sv
// Trap entry/return sequencer: arbitrates exceptions, M-level interrupts and mret,
// drains the pipeline, commits trap CSR state and redirects fetch.
module priv_1_12_trap_ctrl #(
  parameter int XLEN        = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ex_valid,
  input  logic [3:0]      ex_cause,
  input  logic [XLEN-1:0] ex_epc,
  input  logic [XLEN-1:0] ex_tval,
  input  logic [XLEN-1:0] irq_epc,
  input  logic            mip_mei,
  input  logic            mip_msi,
  input  logic            mip_mti,
  input  logic            mie_mei,
  input  logic            mie_msi,
  input  logic            mie_mti,
  input  logic            mstatus_mie,
  input  logic [1:0]      curr_priv,
  input  logic            mret_req,
  input  logic [XLEN-1:0] mepc_in,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic            pipe_drained,
  input  logic            redirect_ack,
  output logic            intr,
  output logic            mret,
  output logic            csr_we,
  output logic [XLEN-1:0] mcause_out,
  output logic [XLEN-1:0] mepc_out,
  output logic [XLEN-1:0] mtval_out,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            fetch_stall,
  output logic            busy
);

  localparam logic [1:0]      M_MODE     = 2'b11;
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cause_q, irq_cause;
  logic            is_irq_q, is_ret_q;
  logic [XLEN-1:0] epc_q, tval_q, rpc_q;
  logic            gie, irq, accept;
  logic [XLEN-1:0] base, vec_off, target;

  assign gie    = (curr_priv != M_MODE) | mstatus_mie;
  assign irq    = gie & ((mip_mei & mie_mei) | (mip_msi & mie_msi) | (mip_mti & mie_mti));
  assign accept = (state_q == IDLE) & (ex_valid | irq | mret_req);

  // Fixed interrupt priority: external > software > timer
  always_comb begin
    irq_cause = 4'd7;
    if (mip_mei & mie_mei)      irq_cause = 4'd11;
    else if (mip_msi & mie_msi) irq_cause = 4'd3;
  end

  assign base    = mtvec_in & ALIGN_MASK;
  assign vec_off = {{(XLEN-6){1'b0}}, cause_q, 2'b00};

  always_comb begin
    target = base;
    if (is_ret_q)
      target = mepc_in & ALIGN_MASK;
    else if (VECTORED_EN && mtvec_in[1:0] == 2'b01 && is_irq_q)
      target = base + vec_off;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      cause_q  <= '0;
      is_irq_q <= 1'b0;
      is_ret_q <= 1'b0;
      epc_q    <= '0;
      tval_q   <= '0;
      rpc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (ex_valid) begin
          cause_q  <= ex_cause;
          is_irq_q <= 1'b0;
          is_ret_q <= 1'b0;
          epc_q    <= ex_epc;
          tval_q   <= ex_tval;
        end else if (irq) begin
          cause_q  <= irq_cause;
          is_irq_q <= 1'b1;
          is_ret_q <= 1'b0;
          epc_q    <= irq_epc;
          tval_q   <= '0;
        end else begin
          is_ret_q <= 1'b1;
        end
      end
      // Target is frozen here so redirect_pc stays stable while waiting for ack
      if (state_q == COMMIT) rpc_q <= target;
    end
  end

  always_comb begin
    state_d        = state_q;
    intr           = 1'b0;
    mret           = 1'b0;
    csr_we         = 1'b0;
    redirect_valid = 1'b0;
    fetch_stall    = 1'b0;
    busy           = (state_q != IDLE);
    case (state_q)
      IDLE: if (accept) state_d = DRAIN;
      DRAIN: begin
        fetch_stall = 1'b1;
        if (pipe_drained) state_d = COMMIT;
      end
      COMMIT: begin
        fetch_stall = 1'b1;
        intr        = ~is_ret_q;
        csr_we      = ~is_ret_q;
        mret        = is_ret_q;
        state_d     = REDIRECT;
      end
      REDIRECT: begin
        fetch_stall    = 1'b1;
        redirect_valid = 1'b1;
        if (redirect_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mcause_out  = {is_irq_q, {(XLEN-5){1'b0}}, cause_q};
  assign mepc_out    = epc_q;
  assign mtval_out   = tval_q;
  assign redirect_pc = rpc_q;

endmodule

// File: tb/tb_priv_1_12_trap_ctrl.sv
// Scoreboard bench for priv_1_12_trap_ctrl: stimulus pushes expected commits,
// a negedge monitor pops and checks them along with the redirect target.
module tb_priv_1_12_trap_ctrl;
  logic        CLK = 0, nRST = 0;
  logic        ex_valid = 0;
  logic [3:0]  ex_cause = 0;
  logic [31:0] ex_epc = 0, ex_tval = 0, irq_epc = 0;
  logic        mip_mei = 0, mip_msi = 0, mip_mti = 0;
  logic        mie_mei = 0, mie_msi = 0, mie_mti = 0;
  logic        mstatus_mie = 0;
  logic [1:0]  curr_priv = 2'b11;
  logic        mret_req = 0;
  logic [31:0] mepc_in = 0, mtvec_in = 0;
  logic        pipe_drained = 1, redirect_ack = 0;
  logic        intr, mret, csr_we, redirect_valid, fetch_stall, busy;
  logic [31:0] mcause_out, mepc_out, mtval_out, redirect_pc;

  int total = 0, bad = 0;

  typedef struct {
    bit          is_ret;
    logic [31:0] mcause, mepc, mtval, rpc;
  } exp_t;
  exp_t q[$];

  priv_1_12_trap_ctrl #(.XLEN(32), .VECTORED_EN(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_cause(ex_cause),
    .ex_epc(ex_epc), .ex_tval(ex_tval), .irq_epc(irq_epc),
    .mip_mei(mip_mei), .mip_msi(mip_msi), .mip_mti(mip_mti),
    .mie_mei(mie_mei), .mie_msi(mie_msi), .mie_mti(mie_mti),
    .mstatus_mie(mstatus_mie), .curr_priv(curr_priv), .mret_req(mret_req),
    .mepc_in(mepc_in), .mtvec_in(mtvec_in), .pipe_drained(pipe_drained),
    .redirect_ack(redirect_ack), .intr(intr), .mret(mret), .csr_we(csr_we),
    .mcause_out(mcause_out), .mepc_out(mepc_out), .mtval_out(mtval_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_stall(fetch_stall), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic push(input bit r, input logic [31:0] c, input logic [31:0] e,
                      input logic [31:0] v, input logic [31:0] pc);
    exp_t x;
    x.is_ret = r; x.mcause = c; x.mepc = e; x.mtval = v; x.rpc = pc;
    q.push_back(x);
  endtask

  task automatic finish_seq(input int ack_delay);
    int n = 0;
    while (!redirect_valid && n < 20) begin tick; n++; end
    chk("redirect_reached", redirect_valid, 1);
    repeat (ack_delay) begin tick; chk("redirect_held", redirect_valid, 1); end
    redirect_ack = 1;
    tick;
    redirect_ack = 0;
    chk("idle_after_ack", busy, 0);
  endtask

  // Monitor: every commit pulse must match the next queued expectation
  exp_t cur;
  bit   have_rpc = 0;
  always @(negedge CLK) begin
    if (nRST) begin
      if (intr || mret) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {30'b0, intr, mret}, 0);
        end else begin
          cur = q.pop_front();
          have_rpc = 1;
          chk("intr_pulse", intr, !cur.is_ret);
          chk("mret_pulse", mret, cur.is_ret);
          chk("csr_we", csr_we, !cur.is_ret);
          if (!cur.is_ret) begin
            chk("mcause", mcause_out, cur.mcause);
            chk("mepc_out", mepc_out, cur.mepc);
            chk("mtval_out", mtval_out, cur.mtval);
          end
        end
      end
      if (redirect_valid && have_rpc) chk("redirect_pc", redirect_pc, cur.rpc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {intr, mret, csr_we, redirect_valid, fetch_stall}, 0);
    chk("rst_mcause", mcause_out, 0);
    chk("rst_rpc", redirect_pc, 0);
    nRST = 1;
    tick;

    // synchronous exception, mtvec vectored but exceptions go to base
    mtvec_in = 32'h8000_0001;
    ex_valid = 1; ex_cause = 4'd2; ex_epc = 32'h100; ex_tval = 32'hDEAD;
    push(0, 32'h2, 32'h100, 32'hDEAD, 32'h8000_0000);
    tick;
    ex_valid = 0;
    chk("ex_drain_busy", busy, 1);
    chk("ex_drain_stall", fetch_stall, 1);
    chk("ex_drain_nointr", intr, 0);
    tick;
    chk("ex_commit_intr", intr, 1);
    chk("ex_commit_we", csr_we, 1);
    finish_seq(0);

    // MEI beats MTI, vectored target base + 11*4
    mstatus_mie = 1; curr_priv = 2'b11; irq_epc = 32'h444;
    mip_mei = 1; mie_mei = 1; mip_mti = 1; mie_mti = 1;
    push(0, 32'h8000_000B, 32'h444, 32'h0, 32'h8000_002C);
    tick;
    mip_mei = 0; mip_mti = 0;
    finish_seq(1);

    // MTI alone, vectored
    irq_epc = 32'h480; mip_mti = 1;
    push(0, 32'h8000_0007, 32'h480, 32'h0, 32'h8000_001C);
    tick;
    mip_mti = 0;
    finish_seq(0);

    // M-mode with MIE clear masks the interrupt; U-mode takes it
    mstatus_mie = 0; mip_msi = 1; mie_msi = 1; irq_epc = 32'h555;
    repeat (3) begin tick; chk("masked_busy", busy, 0); end
    curr_priv = 2'b00;
    push(0, 32'h8000_0003, 32'h555, 32'h0, 32'h8000_000C);
    tick;
    mip_msi = 0; curr_priv = 2'b11;
    chk("umode_busy", busy, 1);
    finish_seq(0);

    // everything at once: exception wins; pipeline not drained for 5 cycles
    mtvec_in = 32'h4000_0000; pipe_drained = 0; mstatus_mie = 1;
    ex_valid = 1; ex_cause = 4'd5; ex_epc = 32'h200; ex_tval = 32'h33;
    mip_mei = 1; mret_req = 1;
    push(0, 32'h5, 32'h200, 32'h33, 32'h4000_0000);
    tick;
    ex_valid = 0; mip_mei = 0; mret_req = 0;
    repeat (5) begin
      chk("hold_busy", busy, 1);
      chk("hold_stall", fetch_stall, 1);
      chk("hold_nopulse", {intr, mret, csr_we}, 0);
      tick;
    end
    pipe_drained = 1;
    tick;
    chk("hold_commit_intr", intr, 1);
    finish_seq(0);

    // mret: target from mepc_in sampled in COMMIT, delayed ack
    mepc_in = 32'h0000_2002; mret_req = 1;
    push(1, 32'h0, 32'h0, 32'h0, 32'h0000_2000);
    tick;
    mret_req = 0;
    tick;
    chk("ret_mret", mret, 1);
    chk("ret_we", csr_we, 0);
    chk("ret_intr", intr, 0);
    tick;
    mepc_in = 32'hFFFF_FFF0;
    finish_seq(3);

    // reset during REDIRECT aborts cleanly
    mtvec_in = 32'h8000_0001;
    ex_valid = 1; ex_cause = 4'd1; ex_epc = 32'h300; ex_tval = 32'h0;
    push(0, 32'h1, 32'h300, 32'h0, 32'h8000_0000);
    tick;
    ex_valid = 0;
    tick;
    tick;
    chk("pre_rst_redirect", redirect_valid, 1);
    nRST = 0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_outs", {intr, mret, csr_we, redirect_valid, fetch_stall}, 0);
    chk("rst_mid_rpc", redirect_pc, 0);
    chk("rst_mid_mcause", mcause_out, 0);
    tick;
    chk("rst_mid_after", {busy, intr, mret}, 0);
    nRST = 1;
    tick;
    chk("post_rst_idle", busy, 0);

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
